// File: rtl/sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// sync_filter_pkg
// Shared types and helpers for the multi-channel sync/trigger filter.
//   sf_state_t : per-channel debounce FSM state
//   GLITCH_W   : width of each per-channel aborted-qualification counter
//   cnt_width  : width of the qualification counter for given assert/deassert
//                run lengths
// -----------------------------------------------------------------------------
package sync_filter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD} sf_state_t;

  localparam int GLITCH_W = 8;

  // Wide enough to hold max(assert, deassert) without wrapping. A zero-width
  // counter cannot be declared, so the degenerate 0/0 case still gets one bit.
  function automatic int cnt_width(input int assert_cycles, input int deassert_cycles);
    int m;
    int w;
    m = (assert_cycles > deassert_cycles) ? assert_cycles : deassert_cycles;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// -----------------------------------------------------------------------------
// sync_filter_chan
// One channel of the sync filter: input synchroniser, assert/deassert
// debounce FSM with separate qualification counts, level output and
// one-cycle start/end pulses.
// Optional: `define SYNC_FILTER_GLITCH_CNT_EN adds an 8-bit saturating count
// of aborted qualification runs.
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   ch_en       channel enable; low forces the channel idle
//   sync_in     raw asynchronous input
//   sync_out    filtered level at ACTIVE_LEVEL polarity
//   start_pulse one-cycle pulse on assertion
//   end_pulse   one-cycle pulse on deassertion
//   glitch_cnt  aborted-run count (only with SYNC_FILTER_GLITCH_CNT_EN)
// -----------------------------------------------------------------------------
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int   ASSERT_CYCLES   = 3,
  parameter int   DEASSERT_CYCLES = 2,
  parameter int   SYNC_STAGES     = 2,
  parameter logic ACTIVE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ch_en,
  input  logic sync_in,
  output logic sync_out,
  output logic start_pulse,
  output logic end_pulse
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = cnt_width(ASSERT_CYCLES, DEASSERT_CYCLES);
  localparam logic [CNT_W-1:0] ASSERT_MAX   = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] DEASSERT_MAX = CNT_W'(DEASSERT_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  sf_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_start;
  logic                   r_end;
  logic                   w_active;

  // Synchroniser: the last stage is the sample the FSM qualifies.
  assign w_active = (r_sync[SYNC_STAGES-1] == ACTIVE_LEVEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Load the inactive level so no edge is seen right after reset.
      r_sync <= {SYNC_STAGES{~ACTIVE_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sync_in};
    end
  end

  // Debounce FSM: r_cnt counts samples opposing the current level beyond the
  // first; any sample agreeing with the current level restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= ~ACTIVE_LEVEL;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_end   <= 1'b0;
      if (!ch_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_out   <= ~ACTIVE_LEVEL;
        r_end   <= (r_state == ST_HELD);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_active) begin
              r_cnt <= '0;
            end else if (r_cnt == ASSERT_MAX) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
              r_out   <= ACTIVE_LEVEL;
              r_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (w_active) begin
              r_cnt <= '0;
            end else if (r_cnt == DEASSERT_MAX) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_out   <= ~ACTIVE_LEVEL;
              r_end   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= ~ACTIVE_LEVEL;
          end
        endcase
      end
    end
  end

  assign sync_out    = r_out;
  assign start_pulse = r_start;
  assign end_pulse   = r_end;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch;
  logic                w_abort;

  // A run aborts when a partially qualified run meets a sample that agrees
  // with the current level again.
  assign w_abort = ch_en && (r_cnt != '0) &&
                   (((r_state == ST_IDLE) && !w_active) ||
                    ((r_state == ST_HELD) &&  w_active));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != {GLITCH_W{1'b1}})) begin
      r_glitch <= r_glitch + 1'b1;
    end
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule

// File: rtl/sync_filter_multi.sv
// -----------------------------------------------------------------------------
// sync_filter_multi
// NUM_CH independent sync/trigger filters (synchroniser + debounce) with
// per-channel polarity, enable, level output and start/end pulses.
// Optional: `define SYNC_FILTER_GLITCH_CNT_EN adds glitch_cnt, one 8-bit
// saturating aborted-run counter per channel (channel i at [8*i +: 8]).
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   ch_en       [NUM_CH] per-channel enable
//   sync_in     [NUM_CH] raw asynchronous sync inputs
//   sync_out    [NUM_CH] filtered levels at ACTIVE_LEVEL polarity
//   start_pulse [NUM_CH] one-cycle assertion pulses
//   end_pulse   [NUM_CH] one-cycle deassertion pulses
//   glitch_cnt  [NUM_CH*8] aborted-run counters (optional)
// -----------------------------------------------------------------------------
module sync_filter_multi
  import sync_filter_pkg::*;
#(
  parameter int                NUM_CH          = 2,
  parameter int                ASSERT_CYCLES   = 3,
  parameter int                DEASSERT_CYCLES = 2,
  parameter int                SYNC_STAGES     = 2,
  parameter logic [NUM_CH-1:0] ACTIVE_LEVEL    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] sync_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] start_pulse,
  output logic [NUM_CH-1:0] end_pulse
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  output logic [NUM_CH*GLITCH_W-1:0] glitch_cnt
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_filter_chan #(
      .ASSERT_CYCLES  (ASSERT_CYCLES),
      .DEASSERT_CYCLES(DEASSERT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LEVEL   (ACTIVE_LEVEL[g])
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .ch_en      (ch_en[g]),
      .sync_in    (sync_in[g]),
      .sync_out   (sync_out[g]),
      .start_pulse(start_pulse[g]),
      .end_pulse  (end_pulse[g])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt[g*GLITCH_W +: GLITCH_W])
`endif
    );
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
module tb_sync_filter_multi;

  localparam int NCH = 2;
  localparam int AC  = 3;
  localparam int DC  = 2;
  localparam int SS  = 2;
  localparam logic [NCH-1:0] AL = 2'b01;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] sync_in;
  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] start_pulse;
  logic [NCH-1:0] end_pulse;
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic [NCH*8-1:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_filter_multi #(
    .NUM_CH         (NCH),
    .ASSERT_CYCLES  (AC),
    .DEASSERT_CYCLES(DC),
    .SYNC_STAGES    (SS),
    .ACTIVE_LEVEL   (AL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_en      (ch_en),
    .sync_in    (sync_in),
    .sync_out   (sync_out),
    .start_pulse(start_pulse),
    .end_pulse  (end_pulse)
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pin values reach the filter SS clocks later; the filter
  // flips its level once it has seen a run of (limit) consecutive samples
  // disagreeing with the current level, where limit is AC+1 to assert and
  // DC+1 to deassert. A broken run with at least one sample counts as a glitch.
  bit m_hist  [NCH][SS];
  bit m_level [NCH];
  int m_run   [NCH];
  int m_glitch[NCH];
  bit m_start [NCH];
  bit m_end   [NCH];

  task automatic model_step();
    bit samp;
    bit act;
    bit opposing;
    int limit;
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        for (int k = 0; k < SS; k++) m_hist[i][k] = ~AL[i];
        m_level[i]  = 1'b0;
        m_run[i]    = 0;
        m_glitch[i] = 0;
        m_start[i]  = 1'b0;
        m_end[i]    = 1'b0;
      end else begin
        samp = m_hist[i][0];
        for (int k = 0; k < SS - 1; k++) m_hist[i][k] = m_hist[i][k+1];
        m_hist[i][SS-1] = sync_in[i];
        m_start[i] = 1'b0;
        m_end[i]   = 1'b0;
        if (!ch_en[i]) begin
          m_end[i]   = m_level[i];
          m_level[i] = 1'b0;
          m_run[i]   = 0;
        end else begin
          act      = (samp == AL[i]);
          opposing = m_level[i] ? !act : act;
          limit    = m_level[i] ? DC + 1 : AC + 1;
          if (opposing) begin
            m_run[i]++;
            if (m_run[i] == limit) begin
              if (m_level[i]) m_end[i] = 1'b1;
              else            m_start[i] = 1'b1;
              m_level[i] = !m_level[i];
              m_run[i]   = 0;
            end
          end else begin
            if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i]++;
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0]   e_out;
    logic [NCH-1:0]   e_st;
    logic [NCH-1:0]   e_en;
    logic [NCH*8-1:0] e_g;
    for (int i = 0; i < NCH; i++) begin
      e_out[i]       = m_level[i] ? AL[i] : ~AL[i];
      e_st[i]        = m_start[i];
      e_en[i]        = m_end[i];
      e_g[i*8 +: 8]  = 8'(m_glitch[i]);
    end
    chk("sync_out", 64'(sync_out), 64'(e_out));
    chk("start_pulse", 64'(start_pulse), 64'(e_st));
    chk("end_pulse", 64'(end_pulse), 64'(e_en));
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    chk("glitch_cnt", 64'(glitch_cnt), 64'(e_g));
`else
    if (e_g == '1) $display("note: glitch model saturated");
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Cycles until the requested pulse on channel ch; 99 if it never comes.
  task automatic wait_pulse(input int ch, input bit want_end, output int n);
    n = 99;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if ((want_end ? end_pulse[ch] : start_pulse[ch]) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    ch_en   = 2'b11;
    sync_in = 2'b10;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_sync_out", 64'(sync_out), 64'(2'b10));
    chk("rst_pulses", 64'({start_pulse, end_pulse}), 64'(0));

    // 1: quiet after reset release
    reset = 1'b0;
    repeat (20) cycle();
    chk("s1_sync_out", 64'(sync_out), 64'(2'b10));

    // 2: assertion and deassertion latency on ch0
    sync_in[0] = 1'b1;
    wait_pulse(0, 1'b0, n);
    chk("s2_assert_lat", 64'(n), 64'(6));
    chk("s2_out_high", 64'(sync_out[0]), 64'(1));
    cycle();
    chk("s2_start_one_cycle", 64'(start_pulse[0]), 64'(0));
    sync_in[0] = 1'b0;
    wait_pulse(0, 1'b1, n);
    chk("s2_deassert_lat", 64'(n), 64'(5));
    chk("s2_out_low", 64'(sync_out[0]), 64'(0));

    // 3: short active burst on ch1 does not qualify
    sync_in[1] = 1'b0;
    repeat (3) cycle();
    sync_in[1] = 1'b1;
    repeat (10) cycle();
    chk("s3_no_assert", 64'(sync_out[1]), 64'(1));
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    chk("s3_glitch_ch1", 64'(glitch_cnt[15:8]), 64'(1));
`endif

    // 4: simultaneous assertion, independent deassertion
    sync_in = 2'b01;
    wait_pulse(0, 1'b0, n);
    chk("s4_start_both", 64'(start_pulse), 64'(2'b11));
    sync_in[0] = 1'b0;
    repeat (3) cycle();
    sync_in[1] = 1'b1;
    repeat (10) cycle();
    chk("s4_idle", 64'(sync_out), 64'(2'b10));

    // 5: disable while held, then re-enable with input still active
    sync_in[0] = 1'b1;
    repeat (10) cycle();
    ch_en[0] = 1'b0;
    cycle();
    chk("s5_dis_out", 64'(sync_out[0]), 64'(0));
    chk("s5_dis_end", 64'(end_pulse[0]), 64'(1));
    ch_en[0] = 1'b1;
    wait_pulse(0, 1'b0, n);
    chk("s5_reassert_lat", 64'(n), 64'(4));

    // 6: reset while held, then reassertion through the reloaded synchroniser
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    chk("s6_rst_out", 64'(sync_out[0]), 64'(0));
    chk("s6_rst_no_end", 64'(end_pulse[0]), 64'(0));
    reset = 1'b0;
    wait_pulse(0, 1'b0, n);
    chk("s6_reassert_lat", 64'(n), 64'(6));

    // Random: sticky inputs with occasional flips, enable drops and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 4) == 0) sync_in[i] = ~sync_in[i];
        if ($urandom_range(0, 99) < 3) ch_en[i] = ~ch_en[i];
        else if (!ch_en[i] && $urandom_range(0, 3) == 0) ch_en[i] = 1'b1;
      end
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_filter_multi.md
Name: sync_filter_multi

Overview:
Parametrised, multi-channel successor to the single-channel VSYNC filter. It runs N independent sync/trigger inputs through a synchroniser and a debounce stage with separate assert and deassert qualification counts, and a per-channel active level. Each channel produces a clean level plus one-cycle start and end pulses. It sits between the video/camera sync pins and the buffer-switch and capture control logic.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
ASSERT_CYCLES, 3, extra consecutive active samples required beyond the first before assertion (0..255)
DEASSERT_CYCLES, 2, extra consecutive inactive samples required beyond the first before deassertion (0..255)
SYNC_STAGES, 2, input synchroniser flops per channel (2..4)
ACTIVE_LEVEL, {NUM_CH{1'b0}}, per-channel active polarity bitmask; bit i = 1 means channel i is active-high

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ch_en  input  NUM_CH  per-channel enable
sync_in  input  NUM_CH  raw asynchronous sync inputs
sync_out  output  NUM_CH  filtered level, at the polarity set by ACTIVE_LEVEL
start_pulse  output  NUM_CH  one-cycle high pulse when sync_out asserts
end_pulse  output  NUM_CH  one-cycle high pulse when sync_out deasserts

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- On reset:
  - sync_out = ~ACTIVE_LEVEL.
  - start_pulse = 0, end_pulse = 0.
  - All channel FSMs go to IDLE and all counters go to 0.
  - Synchroniser flops load the inactive level, so no spurious edge follows reset.
- Reset mid-operation drops sync_out to inactive on the next edge, with no end_pulse.
- Sample definition: the last synchroniser stage, s. A sample is active when s == ACTIVE_LEVEL[i].
- Counter width = $clog2(max(ASSERT_CYCLES, DEASSERT_CYCLES) + 1). The counter never wraps; it is cleared on every transition.
- Per-channel FSM, IDLE:
  - Inactive sample: cnt <= 0.
  - Active sample with cnt == ASSERT_CYCLES: go to HELD, cnt <= 0, sync_out <= active, start_pulse <= 1.
  - Active sample otherwise: cnt++.
- Per-channel FSM, HELD:
  - Active sample: cnt <= 0.
  - Inactive sample with cnt == DEASSERT_CYCLES: go to IDLE, cnt <= 0, sync_out <= inactive, end_pulse <= 1.
  - Inactive sample otherwise: cnt++.
- Illegal state encoding: go to IDLE with outputs inactive.
- Latency, pin to sync_out assertion: SYNC_STAGES + ASSERT_CYCLES + 1 clocks.
- Latency, pin to sync_out deassertion: SYNC_STAGES + DEASSERT_CYCLES + 1 clocks.
- Pulses are high for exactly one cycle and never overlap on one channel. A channel needs at least 1 clock in HELD before it can leave.
- ch_en[i] low forces channel i to IDLE with cnt = 0 and sync_out[i] inactive. It also asserts end_pulse[i] for one cycle if the channel was in HELD. The synchroniser keeps running.
- ch_en[i] rising restarts qualification from cnt = 0. An already-active input asserts after ASSERT_CYCLES + 1 samples.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- With ASSERT_CYCLES = 0, a single active sample asserts sync_out, giving pure synchronisation plus edge pulses.

Optional Feature:
Macro SYNC_FILTER_GLITCH_CNT_EN.
- Defined:
  - Adds output port glitch_cnt, width NUM_CH*8: one 8-bit saturating counter per channel.
  - The counter increments whenever a qualification run aborts: in IDLE when cnt > 0 and the sample goes inactive, or in HELD when cnt > 0 and the sample goes active.
  - Saturates at 255. Cleared by reset only; ch_en does not clear it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package sync_filter_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_HELD} sf_state_t
  - the counter-width function
  - GLITCH_W = 8
- One sub-module, sync_filter_chan: a single channel (synchroniser, FSM, counters, optional glitch counter). It takes the scalar active level as a parameter.
- The top instantiates NUM_CH copies in a generate loop and concatenates the outputs.

Test Plan:
All scenarios use NUM_CH=2, ASSERT_CYCLES=3, DEASSERT_CYCLES=2, SYNC_STAGES=2, ACTIVE_LEVEL=2'b01.
1. Reset release with both inputs inactive (ch0 = 0, ch1 = 1), ch_en = 2'b11 -> sync_out = 2'b10, no pulses for 20 cycles.
2. ch0 goes high at cycle T and holds -> sync_out[0] = 1 and start_pulse[0] = 1 at cycle T+6 only. ch0 then returns low and holds -> sync_out[0] = 0 and end_pulse[0] = 1 at 5 cycles after the falling edge.
3. ch1 goes low (active) for 3 cycles, then high -> no assertion. With the macro defined, glitch_cnt[15:8] = 1.
4. Both channels go active on the same cycle -> start_pulse = 2'b11 in a single cycle. Independent deassertion then gives separate end pulses.
5. ch0 held active in HELD, ch_en[0] dropped -> next cycle sync_out[0] = 0 and end_pulse[0] = 1. Re-enable -> reassertion after 4 cycles.
6. reset asserted while ch0 is in HELD -> sync_out[0] = 0 the next cycle with no end_pulse. After release, reassertion after 6 cycles.
